alarm_responder: RTL and testbench
==================================

# alarm_responder

Consumes the alarm-match flag `Z` and the armed state of the alarm clock, and drives the buzzer. It sits downstream of the time/alarm datapath in the `funct_clk` domain. It starts ringing on the rising edge of the match, supports stop and (optionally) snooze, and auto-silences after a fixed ring period. A sticky `missed` flag reports an alarm that timed out unanswered.

## Interface
Parameters:
- `RING_SEC`, 60: ring duration in seconds (ticks) before auto-silence; legal range 1..2^CNT_W-1.
- `SNOOZE_SEC`, 300: snooze duration in seconds (ticks); legal range 1..2^CNT_W-1.
- `CNT_W`, 9: width of the shared seconds counter.

Ports:
- `funct_clk` in 1: sole clock.
- `rst` in 1: reset. Synchronous and active-high; one clock, `funct_clk`.
- `tick` in 1: one-cycle 1 Hz strobe, synchronous to `funct_clk`.
- `armed` in 1: alarm enable switch (level).
- `z` in 1: time == alarm match flag (level; high for a whole minute).
- `stop` in 1: stop button (debounced level).
- `snooze` in 1: snooze button (debounced level).
- `buzzer` out 1: beep drive, 1 Hz on/off pattern while ringing.
- `ringing` out 1: high in RING.
- `snoozing` out 1: high in SNOOZE.
- `missed` out 1: sticky, set when a ring times out.

## Operation
- Internal rising-edge detection on `z`, `stop` and `snooze`, each using a registered previous value.
- `z` previous value resets to 1, so a `z` already high at reset release does not trigger. `stop`/`snooze` previous values reset to 0.
- States: IDLE, RING, SNOOZE.
- IDLE → RING on `z` rise while `armed`=1. Clear the counter and set beep phase to 1.
- RING:
  - Each `tick` increments the counter and toggles the beep phase.
  - On a `tick` with counter == RING_SEC-1: go to IDLE and set `missed`.
- RING → IDLE on `stop` rise.
- RING → SNOOZE on `snooze` rise. Clear the counter.
- SNOOZE → RING on a `tick` with counter == SNOOZE_SEC-1. Clear the counter and set phase to 1.
- SNOOZE → IDLE on `stop` rise.
- Priority, highest first: `rst`, `armed`=0, `stop` rise, `snooze` rise, `tick` timeout.
- `armed`=0 forces IDLE from any state and clears the counter. `missed` is unchanged.
- `stop` rise in IDLE clears `missed`.
- A `z` rise in RING/SNOOZE is ignored. No queued retrigger.
- After a stop or timeout, `z` remains high for the rest of the minute but cannot retrigger (edge-only).
- `buzzer` = RING & phase. `buzzer` is 0 in IDLE and SNOOZE.
- Counter saturation is not needed: it is cleared on every state entry and bounded by the parameters.

## Timing
- Reset values: state IDLE, counter 0, phase 0, `buzzer`=0, `ringing`=0, `snoozing`=0, `missed`=0.
- All outputs are registered (direct state/flag decode).
- Trigger latency: if `z` is first sampled high at edge N, then `ringing`=1 and `buzzer`=1 after edge N+1.
- Stop latency: if a `stop` rise is sampled at edge N, then `ringing`=0 and `buzzer`=0 after edge N+1.
- RING lasts exactly RING_SEC ticks. `buzzer` toggles on every tick in RING.
- `tick` and a `stop` rise in the same cycle: stop wins. The counter does not advance and `missed` is not set.
- `stop` and `snooze` rising in the same cycle: stop wins, go to IDLE.
- `rst` mid-ring: silenced at the next edge, and no retrigger while `z` stays high.

## Configuration
- `ALARM_SNOOZE_EN` defined: SNOOZE state, `snooze` input and `snoozing` output are functional as described.
- `ALARM_SNOOZE_EN` undefined:
  - The `snooze` input is ignored and `snoozing` is tied to 0.
  - The state machine has only IDLE and RING.
  - `SNOOZE_SEC` is unused.

## Structure
- Shared package `alarm_pkg`: state encodings (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2), default ring and snooze second constants.
- One sub-module, `rise_detect` (synchronous rising-edge detector with parameterised reset value), instantiated for `z`, `stop` and `snooze`.
- FSM, counter and phase live in `alarm_responder`.

## Test plan
Bench parameters: RING_SEC=4, SNOOZE_SEC=3, CNT_W=9, `ALARM_SNOOZE_EN` defined.
- Armed, `z` 0→1 → `ringing`=1 after one edge; `buzzer` pattern over ticks is 1,0,1,0; IDLE with `missed`=1 on the 4th tick; no retrigger while `z` stays high.
- Ringing, `stop` pulse after 2 ticks → IDLE next edge, `buzzer`=0, `missed`=0; a second `z` rise one minute later rings again.
- Ringing, `snooze` rise → `snoozing`=1, `buzzer`=0; after 3 ticks → RING with `buzzer`=1; then `stop` → IDLE.
- Same-cycle `stop` + `tick` at ring count 3 → IDLE, `missed`=0. Same-cycle `stop` + `snooze` → IDLE.
- `z` high through reset release → no ring. `armed`=0 mid-ring → IDLE next edge, `missed` unchanged.
- Rebuild without `ALARM_SNOOZE_EN`: `snooze` pulses during RING have no effect, `snoozing`=0 throughout, timeout still at 4 ticks.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm responder: state encodings and default timing constants.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   localparam int unsigned DEF_RING_SEC   = 60;
   localparam int unsigned DEF_SNOOZE_SEC = 300;
   localparam int unsigned DEF_CNT_W      = 9;

endpackage

// File: rtl/alarm_responder_rise_detect.sv
// Synchronous rising-edge detector; the pulse is registered, so it appears one clock after the edge is sampled.
module rise_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= RST_VAL;
         rise <= 1'b0;
      end else begin
         prev <= d;
         rise <= d & ~prev;
      end
   end

endmodule

// File: rtl/alarm_responder.sv
// Alarm responder: rings on a rising alarm match, stops, snoozes and auto-silences with a sticky missed flag.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_responder
   import alarm_pkg::*;
#(
   parameter int unsigned RING_SEC   = DEF_RING_SEC,
   parameter int unsigned SNOOZE_SEC = DEF_SNOOZE_SEC,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic funct_clk,
   input  logic rst,
   input  logic tick,
   input  logic armed,
   input  logic z,
   input  logic stop,
   input  logic snooze,
   output logic buzzer,
   output logic ringing,
   output logic snoozing,
   output logic missed
);

   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             phase, phase_n;
   logic             missed_q, missed_n;
   logic             tick_d;
   logic             z_rise, stop_rise;

   rise_detect #(.RST_VAL(1'b1)) u_z_rise (
      .clk  (funct_clk),
      .rst  (rst),
      .d    (z),
      .rise (z_rise)
   );

   rise_detect #(.RST_VAL(1'b0)) u_stop_rise (
      .clk  (funct_clk),
      .rst  (rst),
      .d    (stop),
      .rise (stop_rise)
   );

`ifdef ALARM_SNOOZE_EN
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
   logic snooze_rise;

   rise_detect #(.RST_VAL(1'b0)) u_snooze_rise (
      .clk  (funct_clk),
      .rst  (rst),
      .d    (snooze),
      .rise (snooze_rise)
   );
`else
   logic [CNT_W:0] unused_snooze;
   assign unused_snooze = {snooze, CNT_W'(SNOOZE_SEC - 1)};
`endif

   // tick is delayed to line up with the registered edge pulses, so a tick and
   // a button press arriving together are arbitrated in the same cycle.
   always_ff @(posedge funct_clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         phase    <= 1'b0;
         missed_q <= 1'b0;
         tick_d   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         phase    <= phase_n;
         missed_q <= missed_n;
         tick_d   <= tick;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      phase_n  = phase;
      missed_n = missed_q;
      if (!armed) begin
         state_n = IDLE;
         cnt_n   = '0;
         phase_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (stop_rise) begin
                  missed_n = 1'b0;
               end else if (z_rise) begin
                  state_n = RING;
                  cnt_n   = '0;
                  phase_n = 1'b1;
               end
            end
            RING: begin
               if (stop_rise) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  phase_n = 1'b0;
`ifdef ALARM_SNOOZE_EN
               end else if (snooze_rise) begin
                  state_n = SNOOZE;
                  cnt_n   = '0;
                  phase_n = 1'b0;
`endif
               end else if (tick_d) begin
                  if (cnt == RING_LAST) begin
                     state_n  = IDLE;
                     cnt_n    = '0;
                     phase_n  = 1'b0;
                     missed_n = 1'b1;
                  end else begin
                     cnt_n   = cnt + CNT_ONE;
                     phase_n = ~phase;
                  end
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
               if (stop_rise) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  phase_n = 1'b0;
               end else if (tick_d) begin
                  if (cnt == SNOOZE_LAST) begin
                     state_n = RING;
                     cnt_n   = '0;
                     phase_n = 1'b1;
                  end else begin
                     cnt_n = cnt + CNT_ONE;
                  end
               end
            end
`endif
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               phase_n = 1'b0;
            end
         endcase
      end
   end

   assign ringing = (state == RING);
   assign buzzer  = (state == RING) & phase;
   assign missed  = missed_q;
`ifdef ALARM_SNOOZE_EN
   assign snoozing = (state == SNOOZE);
`else
   assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_responder;

   localparam int unsigned RING_SEC   = 4;
   localparam int unsigned SNOOZE_SEC = 3;
   localparam int unsigned CNT_W      = 9;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_RING = 1;
   localparam int M_SNZ  = 2;

   logic funct_clk = 1'b0;
   logic rst = 1'b1, tick = 1'b0, armed = 1'b1, z = 1'b0, stop = 1'b0, snooze = 1'b0;
   logic buzzer, ringing, snoozing, missed;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: mode, ticks elapsed in that mode, sticky missed flag.
   // Edge/tick events sampled at one clock take effect at the following clock.
   int m_mode = M_IDLE;
   int m_el   = 0;
   bit m_missed = 1'b0;
   bit ev_z, ev_stop, ev_snz, ev_tick;
   bit last_z = 1'b1, last_stop = 1'b0, last_snz = 1'b0;

   always #5 funct_clk = ~funct_clk;

   alarm_responder #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .CNT_W      (CNT_W)
   ) dut (
      .funct_clk (funct_clk),
      .rst       (rst),
      .tick      (tick),
      .armed     (armed),
      .z         (z),
      .stop      (stop),
      .snooze    (snooze),
      .buzzer    (buzzer),
      .ringing   (ringing),
      .snoozing  (snoozing),
      .missed    (missed)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_edge();
      if (rst) begin
         m_mode = M_IDLE; m_el = 0; m_missed = 1'b0;
         ev_z = 0; ev_stop = 0; ev_snz = 0; ev_tick = 0;
         last_z = 1'b1; last_stop = 1'b0; last_snz = 1'b0;
      end else begin
         if (!armed) begin
            m_mode = M_IDLE; m_el = 0;
         end else if (m_mode == M_IDLE) begin
            if (ev_stop) m_missed = 1'b0;
            else if (ev_z) begin m_mode = M_RING; m_el = 0; end
         end else if (ev_stop) begin
            m_mode = M_IDLE; m_el = 0;
         end else if (m_mode == M_RING && SNZ_EN && ev_snz) begin
            m_mode = M_SNZ; m_el = 0;
         end else if (ev_tick) begin
            m_el++;
            if (m_mode == M_RING && m_el == RING_SEC) begin
               m_mode = M_IDLE; m_el = 0; m_missed = 1'b1;
            end else if (m_mode == M_SNZ && m_el == SNOOZE_SEC) begin
               m_mode = M_RING; m_el = 0;
            end
         end
         ev_z    = z & ~last_z;
         ev_stop = stop & ~last_stop;
         ev_snz  = snooze & ~last_snz;
         ev_tick = tick;
         last_z = z; last_stop = stop; last_snz = snooze;
      end
   endtask

   task automatic cyc(input bit t);
      tick = t;
      @(posedge funct_clk);
      model_edge();
      #1;
      tick = 1'b0;
      check("ringing", ringing, 32'(m_mode == M_RING));
      check("snoozing", snoozing, 32'(m_mode == M_SNZ));
      check("buzzer", buzzer, 32'(m_mode == M_RING && (m_el % 2) == 0));
      check("missed", missed, 32'(m_missed));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   task automatic tick_gap();
      cyc(1'b1);
      cyc(1'b0);
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(1'b0);
      stop = 1'b0; cyc(1'b0);
   endtask

   initial begin
      // reset state
      idle_cycles(2);
      check("rst_ringing", ringing, 0);
      check("rst_buzzer", buzzer, 0);
      check("rst_snoozing", snoozing, 0);
      check("rst_missed", missed, 0);
      rst = 1'b0;
      idle_cycles(2);

      // trigger, buzzer pattern, timeout, no retrigger
      z = 1'b1; cyc(1'b0);
      check("trig_early", ringing, 0);
      cyc(1'b0);
      check("trig_ringing", ringing, 1);
      check("trig_buzzer", buzzer, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1); cyc(1'b0); cyc(1'b0);
         check("buzz_pattern", buzzer, (i % 2 == 0) ? 0 : 1);
      end
      cyc(1'b1); cyc(1'b0);
      check("timeout_ringing", ringing, 0);
      check("timeout_missed", missed, 1);
      for (int i = 0; i < 6; i++) tick_gap();
      check("no_retrigger", ringing, 0);
      z = 1'b0; idle_cycles(2);

      // stop in IDLE clears missed; stop mid-ring; later minute rings again
      pulse_stop();
      check("stop_clr_missed", missed, 0);
      z = 1'b1; idle_cycles(2);
      tick_gap(); tick_gap();
      stop = 1'b1; cyc(1'b0);
      stop = 1'b0; cyc(1'b0);
      check("stop_ringing", ringing, 0);
      check("stop_buzzer", buzzer, 0);
      check("stop_missed", missed, 0);
      idle_cycles(4); z = 1'b0; idle_cycles(5);
      z = 1'b1; idle_cycles(2);
      check("second_minute_ring", ringing, 1);
      pulse_stop();
      z = 1'b0; idle_cycles(2);

      // snooze, return to ring, stop
      z = 1'b1; idle_cycles(2);
      tick_gap();
      snooze = 1'b1; cyc(1'b0);
      snooze = 1'b0; cyc(1'b0);
      for (int i = 0; i < 3; i++) tick_gap();
      cyc(1'b0);
      pulse_stop();
      z = 1'b0; idle_cycles(2);

      // stop together with the final tick: stop wins, no missed
      z = 1'b1; idle_cycles(2);
      for (int i = 0; i < 3; i++) tick_gap();
      stop = 1'b1; cyc(1'b1);
      stop = 1'b0; cyc(1'b0);
      check("stop_tick_ringing", ringing, 0);
      check("stop_tick_missed", missed, 0);
      z = 1'b0; idle_cycles(2);

      // stop and snooze together
      z = 1'b1; idle_cycles(2);
      stop = 1'b1; snooze = 1'b1; cyc(1'b0);
      stop = 1'b0; snooze = 1'b0; cyc(1'b0);
      check("stop_snz_ringing", ringing, 0);
      check("stop_snz_snoozing", snoozing, 0);

      // z high through reset release
      rst = 1'b1; idle_cycles(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick_gap();
      check("z_through_rst", ringing, 0);
      z = 1'b0; idle_cycles(2);

      // disarm mid-ring after a missed alarm
      z = 1'b1; idle_cycles(2);
      for (int i = 0; i < 4; i++) tick_gap();
      z = 1'b0; idle_cycles(2);
      z = 1'b1; idle_cycles(2);
      tick_gap();
      armed = 1'b0; cyc(1'b0);
      check("disarm_ringing", ringing, 0);
      check("disarm_missed", missed, 1);
      armed = 1'b1; idle_cycles(2);
      z = 1'b0; idle_cycles(2);

      // reset mid-ring
      z = 1'b1; idle_cycles(2);
      rst = 1'b1; cyc(1'b0);
      check("rst_midring", ringing, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick_gap();
      z = 1'b0; idle_cycles(2);

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 79) == 0) armed = ~armed;
         if ($urandom_range(0, 14) == 0) z = ~z;
         if ($urandom_range(0, 11) == 0) stop = ~stop;
         if ($urandom_range(0, 9) == 0) snooze = ~snooze;
         cyc(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
